// File: rtl/uart_txrx.sv
// uart_txrx -- 8N1 UART transmitter and receiver sharing one clock.
//
// The transmit half serialises a byte onto `info` after a one-cycle `send`
// request. The receive half synchronises `rx_info`, centre-samples it and
// delivers the byte on `out` with a one-cycle `valid` strobe.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (integer >= 4)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   din[7:0]   in   byte to transmit, sampled when send is accepted
//   send       in   transmit request, accepted when busy=0
//   busy       out  transmit frame in progress
//   info       out  serial transmit line, registered, idles high
//   rx_info    in   serial receive line, asynchronous to clk
//   out[7:0]   out  last correctly framed received byte
//   valid      out  one-cycle pulse when out is updated
//   frame_err  out  one-cycle pulse when a stop bit is sampled low
//
// Build option:
//   UART_LOOPBACK_EN  when defined, the receiver listens to the internal
//                     transmit line instead of rx_info.
module uart_txrx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       send,
  output logic       busy,
  output logic       info,
  input  logic       rx_info,
  output logic [7:0] out,
  output logic       valid,
  output logic       frame_err
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  // ---------------------------------------------------------------- TX
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_st_t;

  tx_st_t        tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          info_q, info_d;
  logic          busy_q, busy_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= T_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      info_q     <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      info_q     <= info_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      T_IDLE: begin
        if (send) begin
          tx_state_d = T_START;
          tx_shift_d = din;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
        end
      end
      T_START: begin
        if (tx_cnt_q == LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = T_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + ONE;
        end
      end
      T_DATA: begin
        if (tx_cnt_q == LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = T_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = tx_shift_q >> 1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + ONE;
        end
      end
      default: begin
        if (tx_cnt_q == LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = T_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + ONE;
        end
      end
    endcase
  end

  // Outputs are decoded from the next state so the line changes on the
  // same edge as the state (start bit begins on the accepting edge).
  always_comb begin
    info_d = 1'b1;
    busy_d = (tx_state_d != T_IDLE);
    case (tx_state_d)
      T_START: info_d = 1'b0;
      T_DATA:  info_d = tx_shift_d[0];
      default: info_d = 1'b1;
    endcase
  end

  assign info = info_q;
  assign busy = busy_q;

  // ---------------------------------------------------------------- RX
  logic rx_src;
`ifdef UART_LOOPBACK_EN
  assign rx_src = info_q;
`else
  assign rx_src = rx_info;
`endif

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_ERR} rx_st_t;

  logic          rx_meta_q, rx_sync_q;
  rx_st_t        rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    out_q, out_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_meta_q  <= rx_src;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    case (rx_state_q)
      R_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = R_START;
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
        end
      end
      R_START: begin
        // Re-check half a bit in; a line already back high was a glitch.
        if (rx_cnt_q == HALF) begin
          rx_cnt_d   = '0;
          rx_state_d = rx_sync_q ? R_IDLE : R_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + ONE;
        end
      end
      R_DATA: begin
        if (rx_cnt_q == LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + ONE;
        end
      end
      R_STOP: begin
        if (rx_cnt_q == LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = rx_sync_q ? R_IDLE : R_ERR;
        end else begin
          rx_cnt_d = rx_cnt_q + ONE;
        end
      end
      default: begin
        // Bad stop bit: wait for the line to return high before re-arming.
        if (rx_sync_q) rx_state_d = R_IDLE;
      end
    endcase
  end

  always_comb begin
    valid_d = (rx_state_q == R_STOP) && (rx_cnt_q == LAST) && rx_sync_q;
    ferr_d  = (rx_state_q == R_STOP) && (rx_cnt_q == LAST) && !rx_sync_q;
    out_d   = valid_d ? rx_shift_q : out_q;
  end

  assign out       = out_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_txrx.sv
module tb_uart_txrx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       send;
  logic       busy;
  logic       info;
  logic       rx_drv;
  logic       lb;
  logic       rx_info;
  logic [7:0] rx_out;
  logic       valid;
  logic       frame_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Receive-side monitor state
  int         vcnt = 0;
  int         fcnt = 0;
  int         both = 0;
  logic [7:0] vq[$];

  // External loopback lets the bench exercise TX and RX together.
  assign rx_info = lb ? info : rx_drv;

  uart_txrx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .send      (send),
    .busy      (busy),
    .info      (info),
    .rx_info   (rx_info),
    .out       (rx_out),
    .valid     (valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) begin
      vcnt++;
      vq.push_back(rx_out);
    end
    if (frame_err) fcnt++;
    if (valid && frame_err) both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; sends d and checks every cycle of the frame.
  // With inject set, a second request (8'h3F) is raised mid-frame.
  task automatic tx_frame(input logic [7:0] d, input bit inject);
    logic [9:0] fr;
    fr   = {1'b1, d, 1'b0};
    din  = d;
    send = 1'b1;
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clk);
      if (i == 0) send = 1'b0;
      if (inject && i == 10) begin din = 8'h3F; send = 1'b1; end
      if (inject && i == 11) send = 1'b0;
      check($sformatf("tx_info_%0h_c%0d", d, i), 32'(info), 32'(fr[i / CPB]));
      check($sformatf("tx_busy_%0h_c%0d", d, i), 32'(busy), 32'd1);
    end
    @(negedge clk);
    check($sformatf("tx_end_busy_%0h", d), 32'(busy), 32'd0);
    check($sformatf("tx_end_info_%0h", d), 32'(info), 32'd1);
  endtask

  task automatic rx_send(input logic [7:0] d, input logic stop);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rx_drv = fr[b];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    int v0;
    int f0;
    rst    = 1'b0;
    send   = 1'b1;
    din    = 8'hFF;
    rx_drv = 1'b0;
    lb     = 1'b0;

    // Reset held with activity on the inputs
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_drv = ~rx_drv;
      check("rst_info", 32'(info), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out", 32'(rx_out), 32'h00);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_ferr", 32'(frame_err), 32'd0);
    end
    rx_drv = 1'b1;
    send   = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_info", 32'(info), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // Single transmit: 0,1,0,0,0,0,1,0,0,1
    tx_frame(8'h21, 1'b0);

    // Busy rejection: only 8'h35 framed, nothing afterwards
    tx_frame(8'h35, 1'b1);
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      check($sformatf("norepeat_info_c%0d", i), 32'(info), 32'd1);
      check($sformatf("norepeat_busy_c%0d", i), 32'(busy), 32'd0);
    end
    check("no_rx_yet", 32'(vcnt), 32'd0);

    // Loopback, back-to-back frames
    lb = 1'b1;
    tx_frame(8'h21, 1'b0);
    tx_frame(8'h3F, 1'b0);
    repeat (30) @(negedge clk);
    lb = 1'b0;
    check("lb_vcnt", 32'(vcnt), 32'd2);
    check("lb_byte0", 32'(vq.size() > 0 ? vq[0] : 8'hxx), 32'h21);
    check("lb_byte1", 32'(vq.size() > 1 ? vq[1] : 8'hxx), 32'h3F);
    check("lb_out", 32'(rx_out), 32'h3F);
    check("lb_ferr", 32'(fcnt), 32'd0);

    // Framing error: 8'h5A with stop bit 0
    repeat (5) @(negedge clk);
    v0 = vcnt;
    f0 = fcnt;
    rx_send(8'h5A, 1'b0);
    repeat (20) @(negedge clk);
    check("ferr_count", 32'(fcnt - f0), 32'd1);
    check("ferr_novalid", 32'(vcnt - v0), 32'd0);
    check("ferr_out_kept", 32'(rx_out), 32'h3F);

    // One-cycle low glitch
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_novalid", 32'(vcnt - v0), 32'd0);
    check("glitch_noferr", 32'(fcnt - f0), 32'd1);
    check("glitch_out", 32'(rx_out), 32'h3F);

    // Clean externally driven byte
    rx_send(8'hC3, 1'b1);
    repeat (20) @(negedge clk);
    check("rx_vcnt", 32'(vcnt - v0), 32'd1);
    check("rx_out", 32'(rx_out), 32'hC3);
    check("rx_ferr", 32'(fcnt - f0), 32'd1);

    // Reset during TX data bit 4
    din  = 8'h55;
    send = 1'b1;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      send = 1'b0;
    end
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_info", 32'(info), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out", 32'(rx_out), 32'h00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("postrst_info", 32'(info), 32'd1);
    tx_frame(8'h21, 1'b0);

    check("never_both", 32'(both), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
